// File: rtl/custom_protocol_pkg.sv
// Framing constants and FSM state type shared by the custom protocol TX and RX,
// so both ends agree on how a frame is laid out on the bus.
package custom_protocol_pkg;

    localparam int unsigned NIB_W_DEF   = 4;
    localparam int unsigned NIBBLES_DEF = 4;

    localparam logic [3:0] SYNC_NIB  = 4'b1111;
    localparam logic [3:0] START_NIB = 4'b0000;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        GAP
    } frame_state_e;

endpackage

// File: rtl/custom_protocol_tx.sv
// Transmit-side frame generator: accepts a payload into a one-entry pending slot
// and serialises it as SYNC, START and data nibbles with an enforced idle gap.
module custom_protocol_tx
    import custom_protocol_pkg::*;
#(
    parameter int unsigned NIB_W      = NIB_W_DEF,
    parameter int unsigned NIBBLES    = NIBBLES_DEF,
    parameter int unsigned GAP_CYCLES = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_valid,
    input  logic [NIB_W*NIBBLES-1:0] tx_data,
    input  logic                     tx_dir,
    output logic                     tx_ready,
    output logic [NIB_W-1:0]         bus_out,
    output logic                     strobe_out,
    output logic                     dir_out,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned PAY_W = NIB_W * NIBBLES;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    frame_state_e     state_q, state_d;
    logic [PAY_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             dir_q, dir_d;
    logic             pend_full_q, pend_full_d;
    logic [PAY_W-1:0] pend_data_q, pend_data_d;
    logic             pend_dir_q, pend_dir_d;

    logic [NIB_W-1:0] bus_q, bus_d;
    logic             strobe_q, strobe_d;
    logic             dir_out_q, dir_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic accept;
    logic load;

    assign accept = tx_valid && ready_q;
    assign load   = (state_q == IDLE) && pend_full_q && (gap_q >= GAP_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            gap_q       <= GAP_MAX;
            dir_q       <= 1'b1;
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            pend_dir_q  <= 1'b0;
            bus_q       <= '0;
            strobe_q    <= 1'b0;
            dir_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            dir_q       <= dir_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            pend_dir_q  <= pend_dir_d;
            bus_q       <= bus_d;
            strobe_q    <= strobe_d;
            dir_out_q   <= dir_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        dir_d       = dir_q;
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        pend_dir_d  = pend_dir_q;

        if (accept) begin
            pend_full_d = 1'b1;
            pend_data_d = tx_data;
            pend_dir_d  = tx_dir;
        end else if (load) begin
            pend_full_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = pend_data_q;
                    dir_d   = pend_dir_q;
                    state_d = SYNC;
                end
            end
            SYNC:  state_d = START;
            START: begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: begin
                shift_d = shift_q << NIB_W;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = GAP;
                    // Counter holds idle cycles driven so far, the current one included;
                    // the IDLE cycle before the next SYNC completes the gap.
                    gap_d   = GAP_ONE;
                end
            end
            GAP: begin
                if (gap_q != GAP_MAX) gap_d = gap_q + GAP_ONE;
                if (gap_q >= GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs trail the FSM state by one register stage.
    always_comb begin
        bus_d     = '0;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_q != IDLE);
        dir_out_d = dir_q;
        ready_d   = !pend_full_d;
        case (state_q)
            SYNC: begin
                bus_d    = NIB_W'(SYNC_NIB);
                strobe_d = 1'b1;
            end
            START: begin
                bus_d    = NIB_W'(START_NIB);
                strobe_d = 1'b1;
            end
            DATA: begin
                bus_d    = shift_q[PAY_W-1 -: NIB_W];
                strobe_d = 1'b1;
            end
            GAP:     done_d = (gap_q == GAP_ONE);
            default: ;
        endcase
    end

    assign tx_ready   = ready_q;
    assign bus_out    = bus_q;
    assign strobe_out = strobe_q;
    assign dir_out    = dir_out_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_custom_protocol_tx.sv
// Scoreboard bench for custom_protocol_tx: accepted payloads queue their expected
// frame; a negedge monitor compares every bus cycle against it.
module tb_custom_protocol_tx;

    localparam int NIB    = 4;
    localparam int FRAME  = 2 + NIB;
    localparam int PERIOD = 2 + NIB + 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_dir = 1'b0;
    logic        tx_ready;
    logic [3:0]  bus_out;
    logic        strobe_out;
    logic        dir_out;
    logic        busy;
    logic        frame_done;

    custom_protocol_tx #(
        .NIB_W      (4),
        .NIBBLES    (4),
        .GAP_CYCLES (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_dir     (tx_dir),
        .tx_ready   (tx_ready),
        .bus_out    (bus_out),
        .strobe_out (strobe_out),
        .dir_out    (dir_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        dir;
        int          acc;
    } frame_t;

    frame_t q[$];

    int tests = 0;
    int fails = 0;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: frame k must start at max(accept+2, previous start + period).
    int     mon_idx    = -1;
    int     prev_start = -1000;
    int     done_due   = -1;
    int     exp_start;
    int     exp_nib;
    logic   last_dir   = 1'b1;
    frame_t cur;

    always @(negedge clk) begin
        if (!rst) begin
            mon_idx    = -1;
            prev_start = -1000;
            done_due   = -1;
            last_dir   = 1'b1;
        end else begin
            chk("frame_done", int'(frame_done), int'(cyc == done_due));
            if (mon_idx < 0) begin
                if (strobe_out) begin
                    if (q.size() == 0) begin
                        chk("unexpected_frame", int'(strobe_out), 0);
                    end else begin
                        cur       = q.pop_front();
                        exp_start = (cur.acc + 2 > prev_start + PERIOD) ? cur.acc + 2
                                                                        : prev_start + PERIOD;
                        chk("sync_time", cyc, exp_start);
                        prev_start = exp_start;
                        last_dir   = cur.dir;
                        mon_idx    = 0;
                    end
                end else begin
                    chk("idle_bus", int'(bus_out), 0);
                    chk("idle_dir", int'(dir_out), int'(last_dir));
                end
            end
            if (mon_idx >= 0) begin
                if (mon_idx == 0)      exp_nib = 'hF;
                else if (mon_idx == 1) exp_nib = 0;
                else                   exp_nib = int'((cur.data >> (4 * (FRAME - 1 - mon_idx))) & 16'hF);
                chk("nibble", int'(bus_out), exp_nib);
                chk("strobe", int'(strobe_out), 1);
                chk("frame_dir", int'(dir_out), int'(cur.dir));
                chk("busy", int'(busy), 1);
                mon_idx++;
                if (mon_idx == FRAME) begin
                    mon_idx  = -1;
                    done_due = cyc + 1;
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic dir, output int acc);
        int n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_dir   = dir;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            chk("ready_timeout", int'(tx_ready), 1);
            tx_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        q.push_back('{d, dir, acc});
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 16'($urandom);
        tx_dir   = 1'($urandom);
        chk("ready_drop", int'(tx_ready), 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", int'(n < 500), 1);
        repeat (PERIOD) @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_bus"},    int'(bus_out), 0);
        chk({tag, "_strobe"}, int'(strobe_out), 0);
        chk({tag, "_dir"},    int'(dir_out), 1);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_done"},   int'(frame_done), 0);
        chk({tag, "_ready"},  int'(tx_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        #2 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        send(16'hA5C3, 1'b1, a);
        drain();

        send(16'h1234, 1'b1, a);
        send(16'hFEDC, 1'b0, b);
        drain();

        send(16'h5555, 1'b1, a);
        send(16'hAAAA, 1'b0, b);
        send(16'hF0F0, 1'b1, a);
        drain();

        send(16'h0F0F, 1'b1, a);
        send(16'hBEEF, 1'b0, b);
        while (cyc < a + 5) @(negedge clk);
        #2 rst = 1'b0;
        q.delete();
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_stale_busy", int'(busy), 0);
        chk("no_stale_ready", int'(tx_ready), 1);

        for (int i = 0; i < 100; i++) begin
            int idle;
            idle = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            repeat (idle) @(negedge clk);
            send(16'($urandom), 1'($urandom), a);
        end
        drain();
        chk("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
